// File: rtl/rv_mc_ctl_hs_pkg.sv
// Shared constants for the multicycle RISC-V control plane: opcodes, FSM states,
// datapath select encodings, control bundle struct and trap causes.
package rv_ctl_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] F3_LW   = 3'b010;
  localparam logic [2:0] F3_SW   = 3'b010;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_JALR = 3'b000;
  localparam logic [2:0] F3_SR   = 3'b101;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEM_ADDR, S_LW_MEM, S_LW_WB, S_SW_MEM, S_ALU_EXEC,
    S_ALU_WB, S_BR_EXEC, S_JAL_EXEC, S_JALR_EXEC, S_LUI_WB, S_TRAP
  } state_t;

  localparam logic [1:0] PC_INC      = 2'd0;
  localparam logic [1:0] PC_ALU      = 2'd1;
  localparam logic [1:0] PC_ALU_CLR0 = 2'd2;

  localparam logic [1:0] WB_PC     = 2'd0;
  localparam logic [1:0] WB_ALUOUT = 2'd1;
  localparam logic [1:0] WB_MDR    = 2'd2;
  localparam logic [1:0] WB_IMM    = 2'd3;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_J = 3'd3;
  localparam logic [2:0] IMM_U = 3'd4;

  localparam logic ALUA_REG = 1'b0;
  localparam logic ALUA_PCC = 1'b1;
  localparam logic ALUB_REG = 1'b0;
  localparam logic ALUB_IMM = 1'b1;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;

  localparam logic [1:0] TC_NONE    = 2'd0;
  localparam logic [1:0] TC_ILLEGAL = 2'd1;
  localparam logic [1:0] TC_MEM_TO  = 2'd2;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic [1:0] pcsrc;
    logic       pcwrite;
    logic       pccen;
    logic       irwrite;
    logic       mdrwrite;
    logic [1:0] wbsel;
    logic       regwen;
    logic [2:0] immsel;
    logic       asel;
    logic       bsel;
    logic [3:0] alusel;
    logic       retire;
  } ctl_t;

  // Every default encoding is zero, so the idle bundle is all-zero.
  localparam ctl_t CTL_IDLE = '0;

endpackage

// File: rtl/rv_mc_ctl_hs_watchdog.sv
// Memory wait-state watchdog: counts stalled request cycles, flags the cycle in
// which the MEM_TIMEOUT-th stall occurs. MEM_TIMEOUT=0 disables it.
module rv_mem_watchdog #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic cnt_en,
  output logic expired
);

  generate
    if (MEM_TIMEOUT == 0) begin : g_off
      logic unused_wd;
      assign unused_wd = ^{clk, rst_n, clr, cnt_en};
      assign expired = 1'b0;
    end else begin : g_on
      localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
      logic [CW-1:0] cnt;

      // Fires combinationally on the stall that would make the count reach the limit.
      assign expired = cnt_en && (cnt == CW'(MEM_TIMEOUT - 1));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      cnt <= '0;
        else if (clr)    cnt <= '0;
        else if (cnt_en) cnt <= cnt + CW'(1);
      end
    end
  endgenerate

endmodule

// File: rtl/rv_mc_ctl_hs.sv
// Multicycle RISC-V controller with ready/valid memory handshake, timeout watchdog
// and illegal-instruction trap. Optional perf counters under `RV_PERF_CNT_EN.
module rv_mc_ctl_hs
  import rv_ctl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
`ifdef RV_PERF_CNT_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic [1:0]  pcsrc,
  output logic        pcwrite,
  output logic        pccen,
  output logic        irwrite,
  output logic        mdrwrite,
  output logic [1:0]  wbsel,
  output logic        regwen,
  output logic [2:0]  immsel,
  output logic        asel,
  output logic        bsel,
  output logic [3:0]  alusel,
  output logic        retire,
  output logic        trap,
  output logic [1:0]  trap_cause
`ifdef RV_PERF_CNT_EN
  , output logic [CNT_W-1:0] cyc_cnt
  , output logic [CNT_W-1:0] instret_cnt
`endif
);

  state_t     state, nxt;
  ctl_t       c;
  logic       wd_clr, wd_en, wd_exp;
  logic [6:0] opc;
  logic [2:0] f3;
  logic       unused_instr;

  assign opc = instr[6:0];
  assign f3  = instr[14:12];
  assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

  // Any state change restarts the stall count, so each mem state starts fresh.
  assign wd_clr = (nxt != state);
  assign wd_en  = c.mem_req & ~mem_ready;

  rv_mem_watchdog #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wd (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (wd_clr),
    .cnt_en  (wd_en),
    .expired (wd_exp)
  );

  always_comb begin
    nxt = state;
    case (state)
      S_FETCH:     if (mem_ready) nxt = S_DECODE; else if (wd_exp) nxt = S_TRAP;
      S_DECODE: begin
        if ((opc == OP_LOAD && f3 == F3_LW) || (opc == OP_STORE && f3 == F3_SW))
          nxt = S_MEM_ADDR;
        else if (opc == OP_REG || opc == OP_IMM)                   nxt = S_ALU_EXEC;
        else if (opc == OP_BRANCH && (f3 == F3_BEQ || f3 == F3_BNE)) nxt = S_BR_EXEC;
        else if (opc == OP_JAL)                                    nxt = S_JAL_EXEC;
        else if (opc == OP_JALR && f3 == F3_JALR)                  nxt = S_JALR_EXEC;
        else if (opc == OP_LUI)                                    nxt = S_LUI_WB;
        else                                                       nxt = S_TRAP;
      end
      S_MEM_ADDR:  nxt = (opc == OP_STORE) ? S_SW_MEM : S_LW_MEM;
      S_LW_MEM:    if (mem_ready) nxt = S_LW_WB; else if (wd_exp) nxt = S_TRAP;
      S_SW_MEM:    if (mem_ready) nxt = S_FETCH; else if (wd_exp) nxt = S_TRAP;
      S_ALU_EXEC:  nxt = S_ALU_WB;
      S_LW_WB, S_ALU_WB, S_BR_EXEC, S_JAL_EXEC, S_JALR_EXEC, S_LUI_WB: nxt = S_FETCH;
      S_TRAP:      nxt = S_TRAP;
      default:     nxt = S_TRAP;
    endcase
  end

  // Outputs are forced idle while rst_n is low so an in-flight request drops at once.
  always_comb begin
    c = CTL_IDLE;
    if (rst_n) begin
      case (state)
        S_FETCH: begin
          c.mem_req = 1'b1;
          if (mem_ready) begin
            c.irwrite = 1'b1;
            c.pcwrite = 1'b1;
            c.pccen   = 1'b1;
          end
        end
        S_DECODE: begin
          c.asel   = ALUA_PCC;
          c.bsel   = ALUB_IMM;
          c.immsel = IMM_B;
        end
        S_MEM_ADDR: begin
          c.bsel   = ALUB_IMM;
          c.immsel = (opc == OP_STORE) ? IMM_S : IMM_I;
        end
        S_LW_MEM: begin
          c.mem_req  = 1'b1;
          c.mdrwrite = mem_ready;
        end
        S_LW_WB: begin
          c.wbsel  = WB_MDR;
          c.regwen = 1'b1;
          c.retire = 1'b1;
        end
        S_SW_MEM: begin
          c.mem_req = 1'b1;
          c.mem_we  = 1'b1;
          c.retire  = mem_ready;
        end
        S_ALU_EXEC: begin
          if (opc == OP_REG) begin
            c.alusel = {f3, instr[30]};
          end else begin
            c.bsel   = ALUB_IMM;
            c.immsel = IMM_I;
            c.alusel = {f3, (f3 == F3_SR) ? instr[30] : 1'b0};
          end
        end
        S_ALU_WB: begin
          c.wbsel  = WB_ALUOUT;
          c.regwen = 1'b1;
          c.retire = 1'b1;
        end
        S_BR_EXEC: begin
          c.alusel  = ALU_SUB;
          c.pcsrc   = PC_ALU;
          c.pcwrite = zero ^ f3[0];
          c.retire  = 1'b1;
        end
        S_JAL_EXEC: begin
          c.asel    = ALUA_PCC;
          c.bsel    = ALUB_IMM;
          c.immsel  = IMM_J;
          c.pcsrc   = PC_ALU;
          c.pcwrite = 1'b1;
          c.regwen  = 1'b1;
          c.wbsel   = WB_PC;
          c.retire  = 1'b1;
        end
        S_JALR_EXEC: begin
          c.bsel    = ALUB_IMM;
          c.immsel  = IMM_I;
          c.pcsrc   = PC_ALU_CLR0;
          c.pcwrite = 1'b1;
          c.regwen  = 1'b1;
          c.wbsel   = WB_PC;
          c.retire  = 1'b1;
        end
        S_LUI_WB: begin
          c.immsel = IMM_U;
          c.wbsel  = WB_IMM;
          c.regwen = 1'b1;
          c.retire = 1'b1;
        end
        default: c = CTL_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_FETCH;
      trap_cause <= TC_NONE;
    end else begin
      state <= nxt;
      // Only the first entry into TRAP records a cause; DECODE is the only illegal source.
      if (state != S_TRAP && nxt == S_TRAP)
        trap_cause <= (state == S_DECODE) ? TC_ILLEGAL : TC_MEM_TO;
    end
  end

`ifdef RV_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt     <= '0;
      instret_cnt <= '0;
    end else begin
      if (state != S_TRAP) cyc_cnt     <= cyc_cnt + CNT_W'(1);
      if (c.retire)        instret_cnt <= instret_cnt + CNT_W'(1);
    end
  end
`endif

  assign trap     = (state == S_TRAP);
  assign mem_req  = c.mem_req;
  assign mem_we   = c.mem_we;
  assign pcsrc    = c.pcsrc;
  assign pcwrite  = c.pcwrite;
  assign pccen    = c.pccen;
  assign irwrite  = c.irwrite;
  assign mdrwrite = c.mdrwrite;
  assign wbsel    = c.wbsel;
  assign regwen   = c.regwen;
  assign immsel   = c.immsel;
  assign asel     = c.asel;
  assign bsel     = c.bsel;
  assign alusel   = c.alusel;
  assign retire   = c.retire;

endmodule

// File: tb/tb_rv_mc_ctl_hs.sv
// Directed bench for rv_mc_ctl_hs: retire scoreboard (latency + writeback controls)
// plus per-cycle checks of handshake, watchdog, trap and reset behaviour.
module tb_rv_mc_ctl_hs;

  logic        clk = 1'b0;
  logic        rst_n, zero, mem_ready;
  logic [31:0] instr;
  logic        mem_req, mem_we, pcwrite, pccen, irwrite, mdrwrite, regwen, asel, bsel;
  logic        retire, trap;
  logic [1:0]  pcsrc, wbsel, trap_cause;
  logic [2:0]  immsel;
  logic [3:0]  alusel;
`ifdef RV_PERF_CNT_EN
  logic [3:0]  cyc_cnt, instret_cnt;
`endif

  rv_mc_ctl_hs #(
    .MEM_TIMEOUT(15)
`ifdef RV_PERF_CNT_EN
    , .CNT_W(4)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .pcsrc(pcsrc), .pcwrite(pcwrite), .pccen(pccen),
    .irwrite(irwrite), .mdrwrite(mdrwrite), .wbsel(wbsel), .regwen(regwen),
    .immsel(immsel), .asel(asel), .bsel(bsel), .alusel(alusel), .retire(retire),
    .trap(trap), .trap_cause(trap_cause)
`ifdef RV_PERF_CNT_EN
    , .cyc_cnt(cyc_cnt), .instret_cnt(instret_cnt)
`endif
  );

  always #5 clk = ~clk;

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_SRAI = 32'h4030D093;
  localparam logic [31:0] I_ANDI = 32'h4000F093;
  localparam logic [31:0] I_LW   = 32'h0040A283;
  localparam logic [31:0] I_SW   = 32'h0020A423;
  localparam logic [31:0] I_BNE  = 32'h00209463;
  localparam logic [31:0] I_BEQ  = 32'h00208463;
  localparam logic [31:0] I_JAL  = 32'h010000EF;
  localparam logic [31:0] I_JALR = 32'h000100E7;
  localparam logic [31:0] I_LUI  = 32'h123452B7;

  typedef struct {
    int         lat;
    logic       rw;
    logic       pw;
    logic [1:0] ps;
    logic [1:0] wb;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   icyc  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Retire monitor: pop one expectation per retire pulse and check it.
  always @(negedge clk) begin
    if (!rst_n) icyc = 0;
    else begin
      icyc++;
      if (retire) begin
        chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          exp_t e;
          e = sb.pop_front();
          chk("ret_latency", icyc, e.lat);
          chk("ret_regwen", regwen, e.rw);
          chk("ret_pcwrite", pcwrite, e.pw);
          chk("ret_pcsrc", pcsrc, e.ps);
          chk("ret_wbsel", wbsel, e.wb);
        end
        icyc = 0;
      end
    end
  end

  task automatic drv();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    drv();
    rst_n = 1'b0; mem_ready = 1'b0; zero = 1'b0;
    drv();
    rst_n = 1'b1;
  endtask

  task automatic run(input logic [31:0] ins, input int lat, input logic rw, input logic pw,
                     input logic [1:0] ps, input logic [1:0] wb);
    instr = ins; mem_ready = 1'b1;
    sb.push_back('{lat, rw, pw, ps, wb});
    repeat (lat) @(negedge clk);
    drv();
  endtask

  task automatic run_alu(input logic [31:0] ins, input logic [3:0] exp_alu, input logic exp_b);
    instr = ins; mem_ready = 1'b1;
    sb.push_back('{4, 1'b1, 1'b0, 2'd0, 2'd1});
    repeat (3) @(negedge clk);
    chk("alu_alusel", alusel, exp_alu);
    chk("alu_bsel", bsel, exp_b);
    @(negedge clk);
    drv();
  endtask

  initial begin
    #100000;
    $display("FAIL bench_timeout: observed no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst_n = 1'b0; zero = 1'b0; mem_ready = 1'b0; instr = 32'h0;
    #2;
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_trap", trap, 1'b0);
    chk("rst_cause", trap_cause, 2'd0);
    chk("rst_irwrite", irwrite, 1'b0);
    repeat (2) @(posedge clk); #1;

    // ADD with per-cycle checks
    instr = I_ADD; mem_ready = 1'b1; rst_n = 1'b1;
    sb.push_back('{4, 1'b1, 1'b0, 2'd0, 2'd1});
    @(negedge clk);
    chk("add_fetch_irwrite", irwrite, 1'b1);
    chk("add_fetch_pccen", pccen, 1'b1);
    @(negedge clk);
    chk("add_dec_asel", asel, 1'b1);
    chk("add_dec_immsel", immsel, 3'd2);
    @(negedge clk);
    chk("add_exec_alusel", alusel, 4'b0000);
    chk("add_exec_regwen", regwen, 1'b0);
    @(negedge clk);
    drv();

    run_alu(I_SRAI, 4'b1011, 1'b1);
    run_alu(I_ANDI, 4'b1110, 1'b1);

    // LW with three wait states in LW_MEM
    instr = I_LW; mem_ready = 1'b1;
    sb.push_back('{8, 1'b1, 1'b0, 2'd0, 2'd2});
    repeat (3) @(negedge clk);
    chk("lw_addr_immsel", immsel, 3'd0);
    drv(); mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("lw_wait_req", mem_req, 1'b1);
      chk("lw_wait_mdrwrite", mdrwrite, 1'b0);
      chk("lw_wait_we", mem_we, 1'b0);
    end
    drv(); mem_ready = 1'b1;
    @(negedge clk);
    chk("lw_ready_req", mem_req, 1'b1);
    chk("lw_ready_mdrwrite", mdrwrite, 1'b1);
    @(negedge clk);
    drv();

    run(I_SW, 4, 1'b0, 1'b0, 2'd0, 2'd0);
    zero = 1'b0;
    run(I_BNE, 3, 1'b0, 1'b1, 2'd1, 2'd0);
    run(I_BEQ, 3, 1'b0, 1'b0, 2'd1, 2'd0);
    zero = 1'b1;
    run(I_BEQ, 3, 1'b0, 1'b1, 2'd1, 2'd0);
    run(I_BNE, 3, 1'b0, 1'b0, 2'd1, 2'd0);
    zero = 1'b0;
    run(I_JAL, 3, 1'b1, 1'b1, 2'd1, 2'd0);
    run(I_JALR, 3, 1'b1, 1'b1, 2'd2, 2'd0);
    run(I_LUI, 3, 1'b1, 1'b0, 2'd0, 2'd3);

    // 14 stalls then ready on the 15th: ready wins over the watchdog
    instr = I_LUI; mem_ready = 1'b0;
    sb.push_back('{17, 1'b1, 1'b0, 2'd0, 2'd3});
    repeat (14) @(negedge clk);
    drv(); mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("late_ready_trap", trap, 1'b0);
    drv();

    // Illegal instruction
    instr = 32'h0; mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("ill_dec_trap", trap, 1'b0);
    @(negedge clk);
    chk("ill_trap", trap, 1'b1);
    chk("ill_cause", trap_cause, 2'd1);
    @(negedge clk);
    chk("ill_hold_trap", trap, 1'b1);
    chk("ill_hold_req", mem_req, 1'b0);
    do_reset();

    // Reset in the middle of a stalled store
    instr = I_SW; mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    drv(); mem_ready = 1'b0;
    @(negedge clk);
    chk("sw_wait_req", mem_req, 1'b1);
    chk("sw_wait_we", mem_we, 1'b1);
    chk("sw_wait_retire", retire, 1'b0);
    drv(); rst_n = 1'b0; #1;
    chk("sw_rst_req", mem_req, 1'b0);
    chk("sw_rst_we", mem_we, 1'b0);
    drv(); rst_n = 1'b1;
    @(negedge clk);
    chk("sw_rst_fetch_req", mem_req, 1'b1);
    chk("sw_rst_fetch_we", mem_we, 1'b0);

    // Fetch timeout
    do_reset();
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      chk("to_wait_req", mem_req, 1'b1);
      chk("to_wait_trap", trap, 1'b0);
    end
    @(negedge clk);
    chk("to_trap", trap, 1'b1);
    chk("to_cause", trap_cause, 2'd2);
    chk("to_req", mem_req, 1'b0);
    drv(); mem_ready = 1'b1;
    @(negedge clk);
    chk("to_hold_trap", trap, 1'b1);
    chk("to_hold_cause", trap_cause, 2'd2);
    chk("to_hold_irwrite", irwrite, 1'b0);

    // 20 back-to-back JALs from reset
    do_reset();
    for (int i = 0; i < 20; i++) run(I_JAL, 3, 1'b1, 1'b1, 2'd1, 2'd0);
`ifdef RV_PERF_CNT_EN
    chk("perf_instret", instret_cnt, 4'd4);
    chk("perf_cyc", cyc_cnt, 4'd12);
`endif
    chk("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
